sound_arbiter: RTL and testbench
================================

# sound_arbiter

Sequencer and arbiter for the car's single speaker channel. Four sound sources share one tone path: alarm, horn, reverse beep and jingle. The block latches their requests, grants one by fixed priority with preemption, and steps the granted source's beat pattern. It drives the tone-frequency input of the downstream PWM tone generator and the speaker amplifier enable, in place of the single-melody start/stop control.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BEAT_FREQ, 8: beats per second; BEAT_CYC = CLK_FREQ/BEAT_FREQ clock cycles per beat (integer division).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  4  request strobes; bit i = source i; level high for ≥1 cycle.
- cancel  in  4  cancel strobes per source.
- freq  out  32  tone frequency in Hz to the tone generator; 0 = silence.
- amp_en  out  1  amplifier enable; high only in PLAY.
- busy  out  1  high when state ≠ IDLE.
- active_id  out  2  source currently granted (PLAY) or last granted (GAP); 0 in IDLE.
- done  out  1  one-cycle pulse when a sequence completes without cancel or preemption.

## Operation
- Source IDs and priority: 0 alarm (highest), 1 horn, 2 reverse, 3 jingle (lowest).
- Pending bits:
  - `pending[i]` is set on any edge where `req[i]`=1.
  - It is cleared on any edge where `cancel[i]`=1; cancel wins over a same-cycle req.
  - It is cleared when source i is granted.
- Patterns, one tone per beat (Hz):
  - 0: 988,0 repeated, 8 beats.
  - 1: 440 for 4 beats.
  - 2: 1000,0 repeated, 6 beats.
  - 3: 262,262,294,294,330,330,349,349,392,392,440,440,494,494,523,523, 16 beats.
- States: IDLE, PLAY, GAP.
- IDLE, any pending bit set: grant the lowest pending index and enter PLAY. Set beat_idx=0, restart the beat counter, freq=pattern[id][0], amp_en=1.
- PLAY:
  - Each note lasts exactly BEAT_CYC cycles.
  - On the beat tick, if beat_idx < len−1: increment beat_idx and load the next tone.
  - On the tick at beat_idx = len−1: pulse done, enter GAP, freq=0, amp_en=0.
- Preemption: in PLAY, a pending j < active_id grants j on the next edge and restarts at beat 0. The preempted sequence is dropped: no done, no resume.
- Cancel: `cancel[active_id]` in PLAY sends the block to IDLE on the next edge with freq=0 and amp_en=0, and no done. Cancel of a non-active source only clears its pending bit.
- GAP:
  - One beat of silence (BEAT_CYC cycles), then IDLE.
  - GAP is not preemptible.
  - Requests arriving during GAP stay pending.
- Retrigger: `req[active_id]` during PLAY sets pending, so the sequence replays after the GAP.
- Beat counter: width clog2(BEAT_CYC). Counts 0..BEAT_CYC−1; tick when count = BEAT_CYC−1. Reset to 0 on every grant and on GAP entry.

## Timing
- Reset values: freq=0, amp_en=0, busy=0, active_id=0, done=0, pending=0, state IDLE. Reset applies asynchronously mid-operation with no completion behaviour.
- req high in cycle k: pending visible after edge k+1; freq, amp_en and busy valid after edge k+2 (latency 2 edges from IDLE).
- Preemption and cancel: outputs change 2 edges after the req/cancel cycle.
- done is high for exactly the cycle after the final beat tick, coincident with GAP entry.
- Sequence length: len·BEAT_CYC cycles of PLAY, plus BEAT_CYC cycles of GAP before the next grant is possible.
- All outputs are registered.

## Structure
- Package `sound_pkg`:
  - state enum (IDLE, PLAY, GAP).
  - source ID constants.
  - PAT_LEN array.
  - Tone function `pat_tone(id, idx)` returning 32-bit Hz; idx ≥ len returns 0.
- Sub-module `beat_timer`: parameter BEAT_CYC; inputs clk, reset, restart; output tick. Restart forces count to 0.
- Top module: pending register, priority encoder, FSM, beat_idx (5 bits), output registers.

## Test plan
Use CLK_FREQ=80, BEAT_FREQ=8 (BEAT_CYC=10).
- Horn: req=4'b0010 for 1 cycle → freq=440 and amp_en=1 for 40 cycles; done pulse; 10 cycles with freq=0 and busy=1; then busy=0.
- Jingle preempted: req[3], then req[0] during beat 3 → freq=988 two edges later, active_id=0. Alarm completes with one done pulse; jingle never resumes.
- Simultaneous: req=4'b1010 in one cycle → horn plays 40 cycles, 10-cycle GAP, then jingle 160 cycles; two done pulses.
- Cancel: cancel[2] during reverse beat 2 → freq=0, amp_en=0 and busy=0 two edges later; no done.
- Reset: drive reset=0 mid-PLAY → freq, amp_en and busy go to 0 immediately. After release with req=0 the block stays idle, since pending is cleared.
- Retrigger and clash: `req[1]` during horn playback → horn replays after the GAP. Same-cycle req[2] and cancel[2] in IDLE → nothing plays.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg: shared types, source IDs, pattern lengths and the beat
// tone table for the speaker-channel arbiter.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam logic [1:0] SRC_ALARM   = 2'd0;
  localparam logic [1:0] SRC_HORN    = 2'd1;
  localparam logic [1:0] SRC_REVERSE = 2'd2;
  localparam logic [1:0] SRC_JINGLE  = 2'd3;

  localparam logic [4:0] PAT_LEN [4] =
    '{5'd8, 5'd4, 5'd6, 5'd16};

  // Tone in Hz for beat idx of source id; 0 past the pattern end.
  function automatic logic [31:0] pat_tone(
    input logic [1:0] id,
    input logic [4:0] idx
  );
    logic [31:0] t;
    t = 32'd0;
    if (idx < PAT_LEN[id]) begin
      unique case (id)
        SRC_ALARM:   t = idx[0] ? 32'd0 : 32'd988;
        SRC_HORN:    t = 32'd440;
        SRC_REVERSE: t = idx[0] ? 32'd0 : 32'd1000;
        SRC_JINGLE: begin
          // Each jingle note is held for two beats.
          unique case (idx[3:1])
            3'd0: t = 32'd262;
            3'd1: t = 32'd294;
            3'd2: t = 32'd330;
            3'd3: t = 32'd349;
            3'd4: t = 32'd392;
            3'd5: t = 32'd440;
            3'd6: t = 32'd494;
            3'd7: t = 32'd523;
            default: t = 32'd0;
          endcase
        end
        default: t = 32'd0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// beat_timer: free-running beat counter, tick on the last count.
// Ports: clk, reset (async, active low), restart (count to 0), tick.
module beat_timer #(
  parameter int BEAT_CYC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(BEAT_CYC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sound_arbiter.sv
// sound_arbiter: latches four sound requests, grants by fixed priority
// with preemption, steps the beat pattern, drives freq/amp_en/busy/done.
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BEAT_FREQ = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  cancel,
  output logic [31:0] freq,
  output logic        amp_en,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic        done
);

  localparam int BEAT_CYC = CLK_FREQ / BEAT_FREQ;

  state_e      state_q, state_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  canc_q;
  logic [4:0]  beat_q, beat_d;
  logic [31:0] freq_q, freq_d;
  logic        amp_q, amp_d;
  logic        busy_q, busy_d;
  logic [1:0]  act_q, act_d;
  logic        done_q, done_d;

  logic        has_pend;
  logic [1:0]  pend_id;
  logic        grant, adv, fin;
  logic        tick, restart;
  logic [3:0]  clr;
  logic [4:0]  last;

  beat_timer #(
    .BEAT_CYC (BEAT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign restart = grant | fin;
  assign last    = PAT_LEN[act_q] - 5'd1;

  always_comb begin
    has_pend = |pend_q;
    pend_id  = 2'd0;
    priority case (1'b1)
      pend_q[0]: pend_id = 2'd0;
      pend_q[1]: pend_id = 2'd1;
      pend_q[2]: pend_id = 2'd2;
      pend_q[3]: pend_id = 2'd3;
      default:   pend_id = 2'd0;
    endcase
  end

  // Cancel is acted on one edge after it is registered, so an
  // active-source cancel reaches the outputs two edges later.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    adv     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (has_pend) begin
          grant   = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (canc_q[act_q]) begin
          state_d = IDLE;
        end else if (has_pend && pend_id < act_q) begin
          grant = 1'b1;
        end else if (tick) begin
          if (beat_q == last) begin
            fin     = 1'b1;
            state_d = GAP;
          end else begin
            adv = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    freq_d = freq_q;
    amp_d  = amp_q;
    act_d  = act_q;
    beat_d = beat_q;
    busy_d = (state_d != IDLE);
    done_d = fin;
    if (grant) begin
      act_d  = pend_id;
      beat_d = 5'd0;
      freq_d = pat_tone(pend_id, 5'd0);
      amp_d  = 1'b1;
    end else if (adv) begin
      beat_d = beat_q + 5'd1;
      freq_d = pat_tone(act_q, beat_q + 5'd1);
    end else if (state_d != PLAY) begin
      freq_d = 32'd0;
      amp_d  = 1'b0;
      if (state_d == IDLE) act_d = 2'd0;
    end
  end

  // Cancel beats a same-cycle req; a req beats the grant clear.
  always_comb begin
    clr    = grant ? (4'b0001 << pend_id) : 4'b0000;
    pend_d = ((pend_q & ~clr) | req) & ~cancel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= 4'd0;
      canc_q  <= 4'd0;
      beat_q  <= 5'd0;
      freq_q  <= 32'd0;
      amp_q   <= 1'b0;
      busy_q  <= 1'b0;
      act_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      canc_q  <= cancel;
      beat_q  <= beat_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      busy_q  <= busy_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign freq      = freq_q;
  assign amp_en    = amp_q;
  assign busy      = busy_q;
  assign active_id = act_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed scenarios checked each cycle against an
// elapsed-time model of the arbiter, plus literal spot checks.
module tb_sound_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  cancel;
  logic [31:0] freq;
  logic        amp_en;
  logic        busy;
  logic [1:0]  active_id;
  logic        done;

  int n_vec  = 0;
  int n_fail = 0;
  int n_done = 0;

  sound_arbiter #(
    .CLK_FREQ  (80),
    .BEAT_FREQ (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .cancel    (cancel),
    .freq      (freq),
    .amp_en    (amp_en),
    .busy      (busy),
    .active_id (active_id),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int BC = 10;
  int LEN [4] = '{8, 4, 6, 16};
  int TONE [4][16] = '{
    '{988,0,988,0,988,0,988,0,0,0,0,0,0,0,0,0},
    '{440,440,440,440,0,0,0,0,0,0,0,0,0,0,0,0},
    '{1000,0,1000,0,1000,0,0,0,0,0,0,0,0,0,0,0},
    '{262,262,294,294,330,330,349,349,
      392,392,440,440,494,494,523,523}
  };

  // Model: mode 0 idle, 1 play, 2 gap; t = cycles since mode entry.
  int   m_mode, m_id, m_t, m_g;
  bit   m_done, m_gr;
  bit [3:0] m_pend, m_cq;

  function automatic int lowest(input bit [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_id = 0; m_t = 0;
      m_done = 0; m_pend = '0; m_cq = '0;
    end else begin
      m_g = lowest(m_pend);
      m_gr = 0;
      m_done = 0;
      case (m_mode)
        0: if (m_g >= 0) m_gr = 1;
        1: begin
          if (m_cq[m_id]) m_mode = 0;
          else if (m_g >= 0 && m_g < m_id) m_gr = 1;
          else begin
            m_t++;
            if (m_t == LEN[m_id] * BC) begin
              m_mode = 2; m_t = 0; m_done = 1;
            end
          end
        end
        default: begin
          m_t++;
          if (m_t == BC) m_mode = 0;
        end
      endcase
      if (m_gr) begin
        m_mode = 1; m_id = m_g; m_t = 0;
        m_pend[m_g] = 1'b0;
      end
      m_pend = (m_pend | req) & ~cancel;
      m_cq = cancel;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d want %0d",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int ef;
    ef = (m_mode == 1) ? TONE[m_id][m_t / BC] : 0;
    chk("freq", int'(freq), ef);
    chk("amp_en", int'(amp_en), int'(m_mode == 1));
    chk("busy", int'(busy), int'(m_mode != 0));
    chk("active_id", int'(active_id), (m_mode == 0) ? 0 : m_id);
    chk("done", int'(done), int'(m_done));
    if (done === 1'b1) n_done++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] r, input logic [3:0] c);
    req = r; cancel = c;
    step(1);
    req = 4'd0; cancel = 4'd0;
  endtask

  int d0;

  initial begin
    reset = 1'b0; req = 4'd0; cancel = 4'd0;
    step(2);
    chk("rst_freq", int'(freq), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    step(2);

    // Horn: 40 cycles of 440, done, 10-cycle gap.
    d0 = n_done;
    strobe(4'b0010, 4'd0);
    step(1);
    chk("horn_f0", int'(freq), 440);
    chk("horn_amp", int'(amp_en), 1);
    step(39);
    chk("horn_last", int'(freq), 440);
    step(1);
    chk("horn_done", int'(done), 1);
    chk("horn_gapf", int'(freq), 0);
    step(9);
    chk("horn_gapbusy", int'(busy), 1);
    step(1);
    chk("horn_idle", int'(busy), 0);
    chk("horn_ndone", n_done - d0, 1);
    step(3);

    // Jingle preempted by alarm in beat 3.
    d0 = n_done;
    strobe(4'b1000, 4'd0);
    step(1);
    chk("jin_f0", int'(freq), 262);
    step(30);
    chk("jin_b3", int'(freq), 294);
    strobe(4'b0001, 4'd0);
    step(1);
    chk("pre_f", int'(freq), 988);
    chk("pre_id", int'(active_id), 0);
    step(80);
    chk("pre_done", int'(done), 1);
    step(30);
    chk("pre_noresume", int'(busy), 0);
    chk("pre_ndone", n_done - d0, 1);

    // Simultaneous horn and jingle.
    d0 = n_done;
    strobe(4'b1010, 4'd0);
    step(1);
    chk("sim_id1", int'(active_id), 1);
    step(40);
    chk("sim_d1", int'(done), 1);
    step(10);
    chk("sim_idle", int'(busy), 0);
    step(1);
    chk("sim_id3", int'(active_id), 3);
    chk("sim_f3", int'(freq), 262);
    step(159);
    chk("sim_jlast", int'(freq), 523);
    step(1);
    chk("sim_d2", int'(done), 1);
    step(12);
    chk("sim_ndone", n_done - d0, 2);

    // Cancel reverse during beat 2.
    d0 = n_done;
    strobe(4'b0100, 4'd0);
    step(1);
    chk("rev_f0", int'(freq), 1000);
    step(20);
    strobe(4'd0, 4'b0100);
    chk("can_mid", int'(freq), 1000);
    step(1);
    chk("can_f", int'(freq), 0);
    chk("can_amp", int'(amp_en), 0);
    chk("can_busy", int'(busy), 0);
    step(20);
    chk("can_ndone", n_done - d0, 0);

    // Async reset mid-play.
    strobe(4'b0010, 4'd0);
    step(6);
    #2 reset = 1'b0;
    #1;
    chk("ar_freq", int'(freq), 0);
    chk("ar_amp", int'(amp_en), 0);
    chk("ar_busy", int'(busy), 0);
    step(2);
    reset = 1'b1;
    step(20);
    chk("ar_stay", int'(busy), 0);

    // Retrigger horn during playback.
    d0 = n_done;
    strobe(4'b0010, 4'd0);
    step(11);
    strobe(4'b0010, 4'd0);
    step(29);
    chk("rt_d1", int'(done), 1);
    step(10);
    chk("rt_idle", int'(busy), 0);
    step(1);
    chk("rt_replay", int'(freq), 440);
    step(52);
    chk("rt_ndone", n_done - d0, 2);

    // Same-cycle req and cancel in idle.
    strobe(4'b0100, 4'b0100);
    step(5);
    chk("clash", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
